// File: rtl/gate_checker.sv
// Two-input gate truth-table checker: steps a,b through rows 00..11, holds each
// for SETTLE_CYCLES clocks, captures the gate output and compares with expected.
module gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] expected,
    output logic       a,
    output logic       b,
    input  logic       out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result,
    output logic [3:0] fail_mask
);
    // state  | meaning
    // IDLE   | waiting for start; pass/result/fail_mask hold last check
    // DRIVE  | applying row vector on a,b and sampling out after settling
    // DONE   | one-cycle completion pulse, verdict valid
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] row_q, row_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] exp_q, exp_d;
    logic [3:0] result_q, result_d;
    logic [3:0] fail_q, fail_d;
    logic       pass_q, pass_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [1:0] row_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            row_q    <= 2'd0;
            cnt_q    <= 4'd0;
            exp_q    <= 4'd0;
            result_q <= 4'd0;
            fail_q   <= 4'd0;
            pass_q   <= 1'b0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        result_d = result_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        a_d      = a_q;
        b_d      = b_q;
        row_nxt  = row_q + 2'd1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d    = expected;
                    result_d = 4'd0;
                    fail_d   = 4'd0;
                    pass_d   = 1'b0;
                    row_d    = 2'd0;
                    cnt_d    = 4'd0;
                    a_d      = 1'b0;
                    b_d      = 1'b0;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d           = 4'd0;
                    result_d[row_q] = out;
                    if (row_q == 2'd3) begin
                        // Verdict is registered on the final capture so it is valid throughout DONE.
                        state_d = S_DONE;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        pass_d  = (result_d == exp_q);
                        fail_d  = result_d ^ exp_q;
                    end else begin
                        row_d = row_nxt;
                        a_d   = row_nxt[1];
                        b_d   = row_nxt[0];
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == S_DRIVE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign result    = result_q;
    assign fail_mask = fail_q;

endmodule
